// File: rtl/mem_access_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mem_access_controller
// Description : MEM-stage initiator for a byte-addressed, big-endian,
//               word-wide data memory. Sequences read/write strobes, does
//               read-modify-write for sub-word stores and sign/zero-extends
//               sub-word loads. Holds the pipeline until the access is done.
// Config      : define MISALIGN_TRAP_EN to trap misaligned halfword/word
//               accesses; otherwise offending low address bits are cleared.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_controller #(
  parameter int MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        misalign_err,
  output logic        stall,
  output logic [31:0] mem_addr,
  output logic        mem_re,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [31:0] c_mem_limit = 32'(MEM_BYTES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;

  logic        r_write;
  logic [1:0]  r_size;
  logic        r_signed;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_err;
  logic        r_bypass;   // access skipped memory (out of range or trapped)

  logic        w_accept;
  logic        w_word;
  logic        w_half;
  logic [31:0] w_addr;
  logic        w_err;
  logic        w_oor;
  logic [7:0]  w_byte;
  logic [15:0] w_hword;
  logic [31:0] w_ext;
  logic [31:0] w_merge;

  assign w_accept = req_valid & req_ready;
  assign w_word   = req_size[1];
  assign w_half   = (req_size == 2'b01);

`ifdef MISALIGN_TRAP_EN
  // Misaligned halfword/word requests are reported instead of performed
  assign w_addr = req_addr;
  assign w_err  = (w_half & req_addr[0]) | (w_word & (req_addr[1:0] != 2'b00));
`else
  // Misaligned requests are silently aligned down to the access size
  assign w_addr = {req_addr[31:2],
                   w_word ? 2'b00 : {req_addr[1], req_addr[0] & ~w_half}};
  assign w_err  = 1'b0;
`endif

  // Out of range wins over misalignment: no trap is reported for it
  assign w_oor = (w_addr >= c_mem_limit);

  // State register
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Request capture on accept and read-data capture at the end of RD
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      r_write  <= 1'b0;
      r_size   <= 2'b00;
      r_signed <= 1'b0;
      r_addr   <= 32'h0;
      r_wdata  <= 32'h0;
      r_rdata  <= 32'h0;
      r_err    <= 1'b0;
      r_bypass <= 1'b0;
    end else begin
      if (w_accept) begin
        r_write  <= req_write;
        r_size   <= req_size;
        r_signed <= req_signed;
        r_addr   <= w_addr;
        r_wdata  <= req_wdata;
        r_err    <= w_err & ~w_oor;
        r_bypass <= w_err | w_oor;
      end
      if (r_state == RD) r_rdata <= mem_rdata;
    end
  end

  // Next-state logic and handshake/strobe outputs
  always_comb begin
    w_next    = r_state;
    req_ready = 1'b0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    stall     = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        stall     = req_valid;
        if (req_valid) begin
          if (w_oor || w_err)     w_next = RESP;
          else if (!req_write)    w_next = RD;
          else if (w_word)        w_next = WR;
          else                    w_next = RD;
        end
      end
      RD: begin
        mem_re = 1'b1;
        stall  = 1'b1;
        w_next = r_write ? WR : RESP;
      end
      WR: begin
        mem_we = 1'b1;
        stall  = 1'b1;
        w_next = RESP;
      end
      RESP: begin
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Lane extraction for loads (byte offset k lives in bits [31-8k -: 8])
  always_comb begin
    w_byte  = 8'h0;
    case (r_addr[1:0])
      2'd0:    w_byte = r_rdata[31:24];
      2'd1:    w_byte = r_rdata[23:16];
      2'd2:    w_byte = r_rdata[15:8];
      default: w_byte = r_rdata[7:0];
    endcase
    w_hword = r_addr[1] ? r_rdata[15:0] : r_rdata[31:16];
    w_ext   = r_rdata;
    if (r_size == 2'b00)
      w_ext = {{24{r_signed & w_byte[7]}}, w_byte};
    else if (r_size == 2'b01)
      w_ext = {{16{r_signed & w_hword[15]}}, w_hword};
  end

  // Lane insertion for stores: replace only the target lane of the read word
  always_comb begin
    w_merge = r_wdata;
    if (r_size == 2'b00) begin
      w_merge = r_rdata;
      case (r_addr[1:0])
        2'd0:    w_merge[31:24] = r_wdata[7:0];
        2'd1:    w_merge[23:16] = r_wdata[7:0];
        2'd2:    w_merge[15:8]  = r_wdata[7:0];
        default: w_merge[7:0]   = r_wdata[7:0];
      endcase
    end else if (r_size == 2'b01) begin
      w_merge = r_addr[1] ? {r_rdata[31:16], r_wdata[15:0]}
                          : {r_wdata[15:0], r_rdata[15:0]};
    end
  end

  assign resp_valid   = (r_state == RESP);
  assign misalign_err = (r_state == RESP) & r_err;
  assign resp_rdata   = ((r_state == RESP) && !r_write && !r_bypass) ? w_ext : 32'h0;
  assign mem_addr     = {r_addr[31:2], 2'b00};
  assign mem_wdata    = (r_state == WR) ? w_merge : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_controller
// Description : Directed, table-driven bench for mem_access_controller with
//               a word-wide memory model, plus an async-reset-in-WR sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_controller;

  logic        clk;
  logic        Reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        misalign_err;
  logic        stall;
  logic [31:0] mem_addr;
  logic        mem_re;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem [0:255];

  int n_tests = 0;
  int n_fail  = 0;

  mem_access_controller #(.MEM_BYTES(1024)) dut (
    .clk          (clk),
    .Reset        (Reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_signed   (req_signed),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .misalign_err (misalign_err),
    .stall        (stall),
    .mem_addr     (mem_addr),
    .mem_re       (mem_re),
    .mem_we       (mem_we),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: combinational read, write on the rising edge
  assign mem_rdata = mem[mem_addr[9:2]];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
  end

  typedef struct {
    logic        wr;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    int          exp_lat;
    int          exp_re;
    int          exp_we;
    logic [31:0] exp_waddr;
    logic [31:0] exp_wd;
  } vec_t;

  vec_t vecs [20];

  function automatic vec_t mk(input logic wr, input logic [1:0] sz, input logic sg,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] exp_rdata, input int exp_lat,
                              input int exp_re, input int exp_we,
                              input logic [31:0] exp_waddr, input logic [31:0] exp_wd);
    vec_t v;
    v.wr = wr; v.sz = sz; v.sg = sg; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_lat = exp_lat; v.exp_re = exp_re;
    v.exp_we = exp_we; v.exp_waddr = exp_waddr; v.exp_wd = exp_wd;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue one request and watch it until resp_valid (bounded)
  task automatic run_req(input logic wr, input logic [1:0] sz, input logic sg,
                         input logic [31:0] addr, input logic [31:0] wd,
                         output int lat, output logic [31:0] rdata,
                         output int re_n, output int we_n,
                         output logic [31:0] waddr, output logic [31:0] wdat,
                         output logic bad);
    lat = 99; rdata = 32'hX; re_n = 0; we_n = 0;
    waddr = 32'h0; wdat = 32'h0; bad = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg;
    req_addr = addr; req_wdata = wd;
    @(negedge clk);
    if (!req_ready || !stall || mem_re || mem_we) bad = 1'b1;
    @(posedge clk); #1;
    req_valid  = 1'b0;
    req_write  = ~wr;
    req_size   = ~sz;
    req_addr   = 32'hFFFF_FFFF;
    req_wdata  = $urandom;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (mem_re) re_n++;
      if (mem_we) begin
        we_n++;
        waddr = mem_addr;
        wdat  = mem_wdata;
      end
      if (mem_re && mem_we) bad = 1'b1;
      if (misalign_err) bad = 1'b1;
      if (resp_valid) begin
        lat   = c;
        rdata = resp_rdata;
        if (stall || req_ready) bad = 1'b1;
        break;
      end else if (!stall || req_ready) begin
        bad = 1'b1;
      end
    end
  endtask

  int          lat, re_n, we_n;
  logic [31:0] rdata, waddr, wdat;
  logic        bad;
  string       tag;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    Reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;

    //            wr sz    sg addr          wdata          exp_rdata      lat re we waddr         wdata
    vecs[0]  = mk(1, 2'b10, 0, 32'h10,  32'hDEADBEEF, 32'h0,        2, 0, 1, 32'h10,  32'hDEADBEEF);
    vecs[1]  = mk(0, 2'b00, 1, 32'h11,  32'h0,        32'hFFFFFFAD, 2, 1, 0, 32'h0,   32'h0);
    vecs[2]  = mk(0, 2'b00, 0, 32'h11,  32'h0,        32'h000000AD, 2, 1, 0, 32'h0,   32'h0);
    vecs[3]  = mk(1, 2'b00, 0, 32'h12,  32'hFFFFFF55, 32'h0,        3, 1, 1, 32'h10,  32'hDEAD55EF);
    vecs[4]  = mk(0, 2'b01, 1, 32'h12,  32'h0,        32'h000055EF, 2, 1, 0, 32'h0,   32'h0);
    vecs[5]  = mk(0, 2'b01, 1, 32'h13,  32'h0,        32'h000055EF, 2, 1, 0, 32'h0,   32'h0);
    vecs[6]  = mk(0, 2'b10, 0, 32'h400, 32'h0,        32'h0,        1, 0, 0, 32'h0,   32'h0);
    vecs[7]  = mk(1, 2'b01, 0, 32'h10,  32'h12348001, 32'h0,        3, 1, 1, 32'h10,  32'h800155EF);
    vecs[8]  = mk(0, 2'b01, 1, 32'h10,  32'h0,        32'hFFFF8001, 2, 1, 0, 32'h0,   32'h0);
    vecs[9]  = mk(0, 2'b01, 0, 32'h10,  32'h0,        32'h00008001, 2, 1, 0, 32'h0,   32'h0);
    vecs[10] = mk(0, 2'b10, 1, 32'h11,  32'h0,        32'h800155EF, 2, 1, 0, 32'h0,   32'h0);
    vecs[11] = mk(1, 2'b00, 0, 32'h13,  32'h0000007F, 32'h0,        3, 1, 1, 32'h10,  32'h8001557F);
    vecs[12] = mk(0, 2'b00, 1, 32'h13,  32'h0,        32'h0000007F, 2, 1, 0, 32'h0,   32'h0);
    vecs[13] = mk(1, 2'b11, 0, 32'h3FC, 32'h12345678, 32'h0,        2, 0, 1, 32'h3FC, 32'h12345678);
    vecs[14] = mk(0, 2'b10, 0, 32'h3FC, 32'h0,        32'h12345678, 2, 1, 0, 32'h0,   32'h0);
    vecs[15] = mk(0, 2'b00, 1, 32'h3FC, 32'h0,        32'h00000012, 2, 1, 0, 32'h0,   32'h0);
    vecs[16] = mk(1, 2'b00, 0, 32'h400, 32'h000000AA, 32'h0,        1, 0, 0, 32'h0,   32'h0);
    vecs[17] = mk(0, 2'b00, 0, 32'h3FF, 32'h0,        32'h00000078, 2, 1, 0, 32'h0,   32'h0);
    vecs[18] = mk(1, 2'b10, 0, 32'h16,  32'hCAFEF00D, 32'h0,        2, 0, 1, 32'h14,  32'hCAFEF00D);
    vecs[19] = mk(0, 2'b00, 1, 32'h14,  32'h0,        32'hFFFFFFCA, 2, 1, 0, 32'h0,   32'h0);

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ready",  {31'h0, req_ready},    32'h1);
    check("rst_resp",   {31'h0, resp_valid},   32'h0);
    check("rst_mis",    {31'h0, misalign_err}, 32'h0);
    check("rst_re_we",  {30'h0, mem_re, mem_we}, 32'h0);
    check("rst_stall",  {31'h0, stall},        32'h0);
    check("rst_rdata",  resp_rdata,            32'h0);
    check("rst_maddr",  mem_addr,              32'h0);
    check("rst_wdata",  mem_wdata,             32'h0);
    Reset = 1'b0;

    for (int i = 0; i < 20; i++) begin
      run_req(vecs[i].wr, vecs[i].sz, vecs[i].sg, vecs[i].addr, vecs[i].wdata,
              lat, rdata, re_n, we_n, waddr, wdat, bad);
      tag = $sformatf("v%0d", i);
      check({tag, "_lat"},   lat,   vecs[i].exp_lat);
      check({tag, "_rdata"}, rdata, vecs[i].exp_rdata);
      check({tag, "_re"},    re_n,  vecs[i].exp_re);
      check({tag, "_we"},    we_n,  vecs[i].exp_we);
      check({tag, "_proto"}, {31'h0, bad}, 32'h0);
      if (vecs[i].exp_we > 0) begin
        check({tag, "_waddr"}, waddr, vecs[i].exp_waddr);
        check({tag, "_wword"}, wdat,  vecs[i].exp_wd);
      end
    end

    // Async reset during the WR cycle of a byte store: write must be dropped
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 32'h3FD; req_wdata = 32'h000000AA;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("rstwr_rd", {30'h0, mem_re, mem_we}, 32'h2);
    @(negedge clk);
    check("rstwr_wr",    {30'h0, mem_re, mem_we}, 32'h1);
    check("rstwr_merge", mem_wdata, 32'h12AA5678);
    #1 Reset = 1'b1;
    #1;
    check("rstwr_we_drop", {31'h0, mem_we},    32'h0);
    check("rstwr_ready",   {31'h0, req_ready}, 32'h1);
    check("rstwr_stall",   {31'h0, stall},     32'h0);
    @(posedge clk); #2;
    Reset = 1'b0;
    check("rstwr_mem", mem[8'hFF], 32'h12345678);
    run_req(1'b0, 2'b10, 1'b0, 32'h3FC, 32'h0, lat, rdata, re_n, we_n, waddr, wdat, bad);
    check("rstwr_reload", rdata, 32'h12345678);
    check("rstwr_lat",    lat,   2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
